// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze control for load-use, taken-branch and data-memory waits, with timeout watchdog.
// Optional HAZARD_STATS_EN enables saturating stall/flush/freeze event counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_use_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_memread_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             IFID_write_o,
  output logic             stall_select_o,
  output logic             flush_select_o,
  output logic             freeze_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MEMWAIT = 1'b1;
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT_CYCLES - 1);
  logic [0:0] state;
  logic [15:0] wait_cnt;
  logic lu, mw, frz, lu_run, br_run;
  always_comb begin
    lu = EX_memread_i & (EX_rd_i != 5'd0) &
         ((EX_rd_i == ID_rs1_i) | (ID_use_rs2_i & (EX_rd_i == ID_rs2_i)));
    mw = dmem_req_i & ~dmem_ready_i;
    frz = (state == MEMWAIT) | mw;
    lu_run = ~frz & lu;
    br_run = ~frz & ~lu & branch_taken_i;
  end
  // Reset forces a bubble and a flush so nothing half-formed leaves IF/ID.
  assign freeze_o = rst_n_i & frz;
  assign pc_write_o = rst_n_i & ~frz & ~lu;
  assign IFID_write_o = rst_n_i & ~frz & ~lu;
  assign stall_select_o = ~rst_n_i | lu_run;
  assign flush_select_o = ~rst_n_i | br_run;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      wait_cnt <= '0;
      err_timeout_o <= 1'b0;
    end else if (state == RUN) begin
      if (mw) begin
        state <= MEMWAIT;
        wait_cnt <= 16'd1;
      end
    end else if (dmem_ready_i) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      if (wait_cnt < TO) wait_cnt <= wait_cnt + 16'd1;
      if (wait_cnt >= TO_M1) err_timeout_o <= 1'b1;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      freeze_cnt_o <= '0;
    end else begin
      if (lu_run && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (br_run && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      if (frz && freeze_cnt_o != '1) freeze_cnt_o <= freeze_cnt_o + CNT_W'(1);
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign freeze_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic use2, memread, br, req, rdy;
  logic pc_w, ifid_w, stall, flush, freeze, err;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
  int checks = 0;
  int failures = 0;
  // model state: whether an access is outstanding, frozen cycles so far, sticky error, event counts
  bit busy = 0;
  int waited = 0;
  bit m_err = 0;
  int n_stall = 0, n_flush = 0, n_freeze = 0;

  hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_use_rs2_i(use2),
    .EX_rd_i(rd), .EX_memread_i(memread), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_write_o(pc_w), .IFID_write_o(ifid_w), .stall_select_o(stall),
    .flush_select_o(flush), .freeze_o(freeze), .err_timeout_o(err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .freeze_cnt_o(freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int a, input int b, input bit u, input int d, input bit m,
                     input bit t, input bit q, input bit y);
    rs1 = 5'(a); rs2 = 5'(b); use2 = u; rd = 5'(d); memread = m; br = t; req = q; rdy = y;
  endtask

  function automatic int stat(input int v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    bit lu, mw, frz;
    bit e_pc, e_ifid, e_stall, e_flush, e_freeze;
    @(negedge clk);
    lu = memread && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
    mw = req && !rdy;
    frz = busy || mw;
    if (!rst_n) begin
      {e_pc, e_ifid, e_stall, e_flush, e_freeze} = 5'b00110;
      busy = 0; waited = 0; m_err = 0; n_stall = 0; n_flush = 0; n_freeze = 0;
    end else if (frz) {e_pc, e_ifid, e_stall, e_flush, e_freeze} = 5'b00001;
    else if (lu) {e_pc, e_ifid, e_stall, e_flush, e_freeze} = 5'b00100;
    else if (br) {e_pc, e_ifid, e_stall, e_flush, e_freeze} = 5'b11010;
    else {e_pc, e_ifid, e_stall, e_flush, e_freeze} = 5'b11000;
    chk("pc_write", 32'(pc_w), 32'(e_pc));
    chk("ifid_write", 32'(ifid_w), 32'(e_ifid));
    chk("stall_select", 32'(stall), 32'(e_stall));
    chk("flush_select", 32'(flush), 32'(e_flush));
    chk("freeze", 32'(freeze), 32'(e_freeze));
    chk("err_timeout", 32'(err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(stat(n_stall)));
    chk("flush_cnt", 32'(flush_cnt), 32'(stat(n_flush)));
    chk("freeze_cnt", 32'(freeze_cnt), 32'(stat(n_freeze)));
    @(posedge clk);
    if (rst_n) begin
      if (frz) n_freeze = (n_freeze < CMAX) ? n_freeze + 1 : CMAX;
      else if (lu) n_stall = (n_stall < CMAX) ? n_stall + 1 : CMAX;
      else if (br) n_flush = (n_flush < CMAX) ? n_flush + 1 : CMAX;
      if (!busy) begin
        if (mw) begin busy = 1; waited = 1; end
      end else if (rdy) begin
        busy = 0; waited = 0;
      end else begin
        waited = (waited < TO) ? waited + 1 : TO;
        if (waited == TO) m_err = 1;
      end
    end
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // load-use on rs2, then clear, then rs2 not used, then rd=0
    drv(1, 5, 1, 5, 1, 0, 0, 0); tick();
    drv(1, 5, 1, 5, 0, 0, 0, 0); tick();
    drv(1, 5, 0, 5, 1, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 1, 0, 0, 0); tick();
    // branch with load-use yields a stall only; branch alone flushes
    drv(3, 0, 0, 3, 1, 1, 0, 0); tick();
    drv(3, 0, 0, 3, 0, 1, 0, 0); tick();
    // three-cycle wait then ready, with a load-use during the wait
    drv(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drv(7, 0, 0, 7, 1, 0, 1, 0); tick();
    drv(0, 0, 0, 0, 0, 1, 1, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 1, 1); tick();
    chk("wait_release_freeze", 32'(freeze), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 1, 1); tick();
    // five load-use events saturate a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drv(9, 0, 0, 9, 1, 0, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("stall_cnt_sat", 32'(stall_cnt), 32'(stat(3)));
    // watchdog: error after four frozen cycles without ready
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("err_before_timeout", 32'(err), 32'd0);
    tick();
    chk("err_at_timeout", 32'(err), 32'd1);
    tick(); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick();
    chk("err_sticky", 32'(err), 32'd1);
    // reset in the middle of a wait
    drv(0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_freeze", 32'(freeze), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drv($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
